ifu_prefetch: RTL and testbench

Parametrised instruction-fetch unit with a decoupled prefetch queue.
- Issues sequential fetch requests to instruction memory over a valid/ready request channel and accepts in-order responses that may arrive with variable latency.
- Buffers fetched instructions with their PCs in a DEPTH-entry FIFO that feeds the F/D pipeline register.
- Supports decode back-pressure (freeze) and branch/jump redirect with flush of queued and in-flight fetches.

---
 rtl/ifu_pkg.sv | 12 +
 rtl/ifu_fifo.sv | 44 ++++
 rtl/ifu_prefetch.sv | 102 ++++++++++
 tb/tb_ifu_prefetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;
  localparam int unsigned IFU_ADDR_W = 32;
  localparam int unsigned IFU_INST_W = 32;
  localparam logic [IFU_ADDR_W-1:0] IFU_RESET_PC = 32'h0000_3000;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate flag.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  parameter entry_t RESET_ENTRY = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 push_entry,
  output logic [$clog2(DEPTH):0] count,
  output entry_t                 head
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: RESET_ENTRY};
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_entry;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: credit-limited sequential fetch into a prefetch
// queue feeding F/D, with freeze and redirect/flush support.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] i_inst_addr,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] i_inst_rdata,
  output logic              f_valid,
  input  logic              freeze,
  output logic [INST_W-1:0] f_inst,
  output logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] f_pcn
);
  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;
  localparam entry_t RESET_ENTRY = '{pc: RESET_PC, inst: '0};

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW:0]       credit_used;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CW-1:0]     after_resp;
  entry_t            push_entry;
  entry_t            head;

  // Every accepted request reserves a queue slot, so a kept response can never overflow.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign req_valid   = !reset && !redirect && (credit_used < DEPTH_C);
  assign issue       = req_valid && req_ready;
  assign i_inst_addr = fetch_pc;

  assign push       = resp_valid && (drop_cnt == '0) && !redirect;
  assign pop        = f_valid && !freeze && !redirect;
  assign push_entry = '{pc: resp_pc, inst: i_inst_rdata};
  assign after_resp = outstanding - CW'(resp_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
      resp_pc     <= {redirect_pc[ADDR_W-1:2], 2'b00};
      outstanding <= after_resp;
      drop_cnt    <= after_resp;
    end else begin
      if (issue) fetch_pc <= fetch_pc + STEP;
      outstanding <= after_resp + CW'(issue);
      if (resp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1'b1);
        else                resp_pc  <= resp_pc + STEP;
      end
    end
  end

  ifu_fifo #(
    .DEPTH      (DEPTH),
    .entry_t    (entry_t),
    .RESET_ENTRY(RESET_ENTRY)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_entry(push_entry),
    .count     (count),
    .head      (head)
  );

  assign f_valid = (count != '0);
  assign f_inst  = head.inst;
  assign f_pc    = head.pc;
  assign f_pcn   = head.pc + STEP;
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a variable-latency in-order memory model
// and a stream scoreboard on issued addresses and popped entries.
module tb_ifu_prefetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] i_inst_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] i_inst_rdata = '0;
  logic        f_valid;
  logic        freeze = 1'b0;
  logic [31:0] f_inst;
  logic [31:0] f_pc;
  logic [31:0] f_pcn;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .ADDR_W  (32),
    .INST_W  (32),
    .DEPTH   (4),
    .RESET_PC(32'h0000_3000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .i_inst_addr (i_inst_addr),
    .resp_valid  (resp_valid),
    .i_inst_rdata(i_inst_rdata),
    .f_valid     (f_valid),
    .freeze      (freeze),
    .f_inst      (f_inst),
    .f_pc        (f_pc),
    .f_pcn       (f_pcn)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  typedef struct {
    logic        rdy;
    logic        frz;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_fv;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t       memq[$];
  logic [31:0] isslog[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned npop = 0;
  logic [31:0] exp_issue = 32'h3000;
  logic [31:0] exp_pop = 32'h3000;
  logic        chk_fv_zero = 1'b0;
  vec_t        tbl[12];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] issued(input int unsigned k);
    return (isslog.size() > k) ? isslog[k] : 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge: present this cycle's memory response and let it settle.
  task automatic drive_mem();
    mreq_t r;
    resp_valid   = 1'b0;
    i_inst_rdata = '0;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      r            = memq.pop_front();
      resp_valid   = 1'b1;
      i_inst_rdata = inst_of(r.addr);
    end
    #1;
  endtask

  // Scoreboard the settled cycle, then advance to the next falling edge.
  task automatic finish_cycle();
    if (chk_fv_zero) chk("fv_after_redirect", f_valid, 1'b0);
    chk_fv_zero = 1'b0;
    if (redirect) chk("rv_in_redirect", req_valid, 1'b0);
    if (req_valid && req_ready) begin
      chk("issue_addr", i_inst_addr, exp_issue);
      exp_issue = exp_issue + 32'd4;
      isslog.push_back(i_inst_addr);
      memq.push_back('{i_inst_addr, cyc + lat});
    end
    if (f_valid && !freeze && !redirect) begin
      chk("pop_pc", f_pc, exp_pop);
      chk("pop_inst", f_inst, inst_of(exp_pop));
      chk("pop_pcn", f_pcn, exp_pop + 32'd4);
      exp_pop = exp_pop + 32'd4;
      npop++;
    end
    if (redirect) begin
      exp_issue   = {redirect_pc[31:2], 2'b00};
      exp_pop     = {redirect_pc[31:2], 2'b00};
      chk_fv_zero = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycle();
    drive_mem();
    finish_cycle();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect_cycle(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    isslog.delete();
    npop = 0;
    cycle();
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    redirect   = 1'b0;
    freeze     = 1'b0;
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    memq.delete();
    @(posedge clk);
    #1;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_f_valid", f_valid, 1'b0);
    chk("rst_f_inst", f_inst, 32'h0);
    chk("rst_f_pc", f_pc, 32'h3000);
    chk("rst_f_pcn", f_pcn, 32'h3004);
    @(posedge clk);
    @(negedge clk);
    reset       = 1'b0;
    exp_issue   = 32'h3000;
    exp_pop     = 32'h3000;
    chk_fv_zero = 1'b0;
    isslog.delete();
    npop = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {rdy, frz, exp_rv, exp_addr, exp_fv, exp_pc}, zero-wait memory from reset release
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h3000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h3004, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h3008, 1'b1, 32'h3000};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h300C, 1'b1, 32'h3004};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h3010, 1'b1, 32'h3008};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h3014, 1'b1, 32'h300C};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h3018, 1'b1, 32'h3010};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h301C, 1'b1, 32'h3010};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h3020, 1'b1, 32'h3014};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h3024, 1'b1, 32'h3018};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h3024, 1'b1, 32'h301C};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h3028, 1'b1, 32'h3020};

    lat = 1;
    do_reset();
    for (int unsigned i = 0; i < 12; i++) begin
      req_ready = tbl[i].rdy;
      freeze    = tbl[i].frz;
      drive_mem();
      chk("tbl_req_valid", req_valid, tbl[i].exp_rv);
      if (tbl[i].exp_rv) chk("tbl_addr", i_inst_addr, tbl[i].exp_addr);
      chk("tbl_f_valid", f_valid, tbl[i].exp_fv);
      if (tbl[i].exp_fv) begin
        chk("tbl_f_pc", f_pc, tbl[i].exp_pc);
        chk("tbl_f_pcn", f_pcn, tbl[i].exp_pc + 32'd4);
      end
      finish_cycle();
    end
    req_ready = 1'b1;
    freeze    = 1'b0;

    // Freeze from reset release: queue fills to DEPTH, then drains in order.
    do_reset();
    freeze = 1'b1;
    run(10);
    drive_mem();
    chk("frz_issues", isslog.size(), 4);
    chk("frz_req_valid", req_valid, 1'b0);
    chk("frz_f_valid", f_valid, 1'b1);
    chk("frz_head", f_pc, 32'h3000);
    freeze = 1'b0;
    finish_cycle();
    run(5);
    chk("frz_drain_pops", npop, 6);

    // Redirect with two requests outstanding and no response in that cycle.
    lat = 4;
    do_reset();
    run(2);
    redirect_cycle(32'h3100);
    run(15);
    chk("r1_first_issue", issued(0), 32'h3100);
    chk("r1_pops_ge3", npop >= 3, 1'b1);

    // Redirect coinciding with a response while another request is in flight.
    lat = 2;
    do_reset();
    run(6);
    redirect_cycle(32'h3200);
    run(12);
    chk("r2_first_issue", issued(0), 32'h3200);
    chk("r2_pops_ge3", npop >= 3, 1'b1);

    // Misaligned target and address-space wrap.
    lat = 1;
    run(3);
    redirect_cycle(32'h3103);
    run(6);
    chk("r3_first_issue", issued(0), 32'h3100);
    redirect_cycle(32'hFFFF_FFFC);
    run(6);
    chk("r4_issue0", issued(0), 32'hFFFF_FFFC);
    chk("r4_issue1", issued(1), 32'h0000_0000);
    chk("r4_pops_ge3", npop >= 3, 1'b1);

    // Asynchronous reset mid-burst with three entries queued.
    lat = 1;
    do_reset();
    freeze = 1'b1;
    run(4);
    drive_mem();
    reset = 1'b1;
    #1;
    chk("async_rst_f_valid", f_valid, 1'b0);
    chk("async_rst_req_valid", req_valid, 1'b0);
    do_reset();
    run(5);
    chk("post_rst_issue0", issued(0), 32'h3000);
    chk("post_rst_pops", npop, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
